// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// counter sizing helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sa_state_t;

  localparam int SA_MIN_WIDTH = 2;
  localparam int SA_MAX_WIDTH = 32;

  // One spare bit so the bit counter never wraps while reaching WIDTH-1.
  function automatic int sa_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational full-adder bit cell built from two half adders and an OR.
module full_adder_bit (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic s_out,
  output logic c_out
);

  logic s1, c1, c2;

  half_adder u_ha0 (
    .a_in  (a_in),
    .b_in  (b_in),
    .s_out (s1),
    .c_out (c1)
  );

  half_adder u_ha1 (
    .a_in  (s1),
    .b_in  (c_in),
    .s_out (s_out),
    .c_out (c2)
  );

  assign c_out = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder: sum and carry of two input bits.
module half_adder (
  input  logic a_in,
  input  logic b_in,
  output logic s_out,
  output logic c_out
);

  assign s_out = a_in ^ b_in;
  assign c_out = a_in & b_in;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell reused over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf_out
`endif
);

  localparam int CNT_W = sa_cnt_width(WIDTH);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             bit_s, bit_c;
  logic [WIDTH-1:0] sum_next;

  full_adder_bit u_fa (
    .a_in  (a_sr_q[0]),
    .b_in  (b_sr_q[0]),
    .c_in  (carry_q),
    .s_out (bit_s),
    .c_out (bit_c)
  );

  // Sum bits collected so far sit in the low WIDTH-1 bits; the new bit enters at the top.
  assign sum_next = {bit_s, sum_sr_q};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      done_q   <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start_in) begin
          a_sr_d  = a_in;
          b_sr_d  = b_in;
          carry_d = cin_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        carry_d  = bit_c;
        sum_sr_d = sum_next[WIDTH-1:1];
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = sum_next;
          cout_d  = bit_c;
          done_d  = 1'b1;
          state_d = DONE;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB while the MSB is being added.
          ovf_d   = carry_q ^ bit_c;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_out = (state_q == SHIFT);
  assign done_out = done_q;
  assign sum_out  = sum_q;
  assign cout_out = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf_out  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder against an arithmetic reference model.
// Covers ovf_out as well when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks   = 0;
  int failures = 0;

  logic [WIDTH-1:0] prev_sum  = '0;
  logic             prev_cout = 1'b0;
  logic             prev_ovf  = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .start_in (start),
    .a_in     (a),
    .b_in     (b),
    .cin_in   (cin),
    .busy_out (busy),
    .done_out (done),
    .sum_out  (sum),
    .cout_out (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf_out  (ovf)
`endif
  );

`ifndef SERIAL_ADDER_OVF_EN
  assign ovf = 1'b0;
`endif

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [WIDTH+1:0] ref_add(input logic [WIDTH-1:0] av,
                                                input logic [WIDTH-1:0] bv,
                                                input logic cv);
    longint ua, ub, sa, sb, ur, sr;
    logic   o;
    ua = longint'(av);
    ub = longint'(bv);
    sa = av[WIDTH-1] ? ua - (longint'(1) << WIDTH) : ua;
    sb = bv[WIDTH-1] ? ub - (longint'(1) << WIDTH) : ub;
    ur = ua + ub + longint'(cv);
    sr = sa + sb + longint'(cv);
    o  = (sr > ((longint'(1) << (WIDTH - 1)) - 1)) || (sr < -(longint'(1) << (WIDTH - 1)));
`ifndef SERIAL_ADDER_OVF_EN
    o  = 1'b0;
`endif
    return {o, ur[WIDTH:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_add(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic cv, input string tag);
    logic [WIDTH+1:0] exp;
    exp   = ref_add(av, bv, cv);
    start = 1'b1; a = av; b = bv; cin = cv;
    tick;
    start = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom_range(0, 1));
    for (int k = 0; k < WIDTH; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s shift_phase k=%0d: busy=%b done=%b, want busy=1 done=0", tag, k, busy, done);
      end
      checks++;
      if ({ovf, cout, sum} !== {prev_ovf, prev_cout, prev_sum}) begin
        failures++;
        $display("FAIL %s result_hold k=%0d: got %h want %h", tag, k, {ovf, cout, sum},
                 {prev_ovf, prev_cout, prev_sum});
      end
      if (k == 3) begin
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_pulse: busy=%b done=%b, want busy=0 done=1", tag, busy, done);
    end
    checks++;
    if ({ovf, cout, sum} !== exp) begin
      failures++;
      $display("FAIL %s result a=%h b=%h cin=%b: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
               tag, av, bv, cv, ovf, cout, sum, exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
    end
    {prev_ovf, prev_cout, prev_sum} = exp;
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s done_clear: busy=%b done=%b, want 0 0", tag, busy, done);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '1; b = '1; cin = 1'b1;
    repeat (3) tick;
    checks++;
    if ({busy, done, ovf, cout, sum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h want 0", {busy, done, ovf, cout, sum});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick;
    checks++;
    if ({busy, done, ovf, cout, sum} !== '0) begin
      failures++;
      $display("FAIL idle_after_reset: got %h want 0", {busy, done, ovf, cout, sum});
    end
  endtask

  task automatic test_directed;
    do_add(8'h3C, 8'h5A, 1'b0, "add_3c_5a");
    do_add(8'hFF, 8'h01, 1'b0, "add_ff_01");
    do_add(8'h00, 8'h00, 1'b1, "add_cin_only");
    do_add(8'hFF, 8'hFF, 1'b1, "add_all_ones");
  endtask

  task automatic test_overflow;
    do_add(8'h7F, 8'h01, 1'b0, "ovf_7f_01");
    do_add(8'h80, 8'h80, 1'b0, "ovf_80_80");
    do_add(8'h40, 8'h3F, 1'b0, "no_ovf_40_3f");
  endtask

  task automatic test_back_to_back;
    localparam int NOPS = 4;
    logic [WIDTH-1:0] opa [NOPS];
    logic [WIDTH-1:0] opb [NOPS];
    logic             opc [NOPS];
    logic [WIDTH+1:0] exp;
    int               idx, phase;
    start = 1'b1;
    for (int cyc = 0; cyc < NOPS * (WIDTH + 1); cyc++) begin
      idx   = cyc / (WIDTH + 1);
      phase = cyc % (WIDTH + 1);
      a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom_range(0, 1));
      if (phase == 0) begin
        opa[idx] = a; opb[idx] = b; opc[idx] = cin;
      end
      tick;
      if (phase == WIDTH) begin
        exp = ref_add(opa[idx], opb[idx], opc[idx]);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || {ovf, cout, sum} !== exp) begin
          failures++;
          $display("FAIL b2b_result op=%0d: done=%b busy=%b got %h want done=1 busy=0 %h",
                   idx, done, busy, {ovf, cout, sum}, exp);
        end
        {prev_ovf, prev_cout, prev_sum} = exp;
      end else begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || {ovf, cout, sum} !== {prev_ovf, prev_cout, prev_sum}) begin
          failures++;
          $display("FAIL b2b_shift op=%0d phase=%0d: done=%b busy=%b out=%h want done=0 busy=1 out=%h",
                   idx, phase, done, busy, {ovf, cout, sum}, {prev_ovf, prev_cout, prev_sum});
        end
      end
    end
    start = 1'b0;
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_mid_reset;
    start = 1'b1; a = 8'hA5; b = 8'h5A; cin = 1'b1;
    tick;
    start = 1'b0;
    repeat (4) tick;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ovf, cout, sum} !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs: got %h want 0", {busy, done, ovf, cout, sum});
    end
    for (int k = 0; k < WIDTH; k++) begin
      tick;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_done k=%0d: done=%b busy=%b want 0 0", k, done, busy);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL resume_idle: done=%b busy=%b want 0 0", done, busy);
    end
    prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
    do_add(8'h10, 8'h20, 1'b0, "after_reset_10_20");
  endtask

  task automatic test_random;
    for (int n = 0; n < 1000; n++) begin
      do_add(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_directed;
    test_overflow;
    test_back_to_back;
    test_mid_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
